human_input_responder: RTL

//  Responder side of the processor's human-input transaction. When control_Human_Interface

---
 rtl/human_input_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/human_input_responder.sv
// Responder for the processor's human-input transaction.
// Stalls the core while an input request is outstanding. It waits for a debounced
// ENTER press, latches the switches as an extended data word, and releases the core
// with a one-cycle input_valid pulse once the key has been let go.
module human_input_responder #(
  parameter int         IO_WIDTH        = 16,
  parameter int         DATA_WIDTH      = 32,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [1:0] REQ_CODE        = 2'b10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            control_Human_Interface,
  input  logic                  sign_extend,
  input  logic                  enter_key_n,
  input  logic [IO_WIDTH-1:0]   sw,
  output logic [DATA_WIDTH-1:0] IData,
  output logic                  input_valid,
  output logic                  stall,
  output logic                  waiting_led
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    RELEASE,
    DONE
  } stateT;

  stateT r_state;
  stateT w_nextState;

  logic                  r_syncMeta;
  logic                  r_syncOut;
  logic                  r_keyDb;
  logic                  r_keyDbQ;
  logic [CW-1:0]         r_dbCount;
  logic [DATA_WIDTH-1:0] r_iData;

  logic                  w_keySync;
  logic                  w_pressEdge;
  logic                  w_req;
  logic [DATA_WIDTH-1:0] w_extWord;

  assign w_keySync   = ~r_syncOut;
  assign w_pressEdge = r_keyDb & ~r_keyDbQ;
  assign w_req       = (control_Human_Interface == REQ_CODE);

  // Two-flop synchronizer for the asynchronous key; idles at the released (high) level.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_syncMeta <= 1'b1;
      r_syncOut  <= 1'b1;
    end else begin
      r_syncMeta <= enter_key_n;
      r_syncOut  <= r_syncMeta;
    end
  end

  // Debouncer: the key level only changes after it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_keyDb   <= 1'b0;
      r_keyDbQ  <= 1'b0;
      r_dbCount <= '0;
    end else begin
      r_keyDbQ <= r_keyDb;
      if (w_keySync != r_keyDb) begin
        if (r_dbCount == DB_LAST) begin
          r_keyDb   <= w_keySync;
          r_dbCount <= '0;
        end else begin
          r_dbCount <= r_dbCount + CW'(1);
        end
      end else begin
        r_dbCount <= '0;
      end
    end
  end

  // Extend the switch value to the data width; the upper bits copy the switch MSB when signed.
  always_comb begin
    w_extWord                 = {DATA_WIDTH{sign_extend & sw[IO_WIDTH-1]}};
    w_extWord[IO_WIDTH-1:0]   = sw;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Transaction sequencing; a cancel is honoured only while still waiting for the press.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_req) w_nextState = ARMED;
      ARMED: begin
        if (!w_req)           w_nextState = IDLE;
        else if (w_pressEdge) w_nextState = CAPTURE;
      end
      CAPTURE: w_nextState = RELEASE;
      RELEASE: if (!r_keyDb) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Data capture register; holds the word until the next capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_iData <= '0;
    end else if (r_state == CAPTURE) begin
      r_iData <= w_extWord;
    end
  end

  // Handshake outputs decoded from state; stall drops in DONE so the core consumes IData.
  always_comb begin
    stall       = ((r_state == IDLE) && w_req) ||
                  (r_state == ARMED) || (r_state == CAPTURE) || (r_state == RELEASE);
    input_valid = (r_state == DONE);
    waiting_led = (r_state == ARMED);
  end

  assign IData = r_iData;

endmodule
